conv_dot_pipe: RTL and testbench

CONV_DOT_PIPE -- requirements
Module: conv_dot_pipe

---
 rtl/conv_dot_pipe.sv | 142 ++++++++++++++
 tb/tb_conv_dot_pipe.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_dot_pipe.sv
// conv_dot_pipe: 4-stage IFM x weight dot-product pipeline with a locked weight file.
// Optional output bias enabled by defining CONV_BIAS_EN.
module conv_dot_pipe #(
  parameter  int N_ELEM = 32,
  parameter  int DATA_W = 4,
  parameter  int W_W    = 4,
  localparam int AW     = $clog2(N_ELEM),
  localparam int OUT_W  = DATA_W + W_W + AW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_ELEM*DATA_W-1:0] in_data,
  input  logic                     w_we,
  input  logic [AW-1:0]            w_addr,
  input  logic [W_W-1:0]           w_data,
  output logic                     w_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     busy,
  output logic [15:0]              beat_cnt
`ifdef CONV_BIAS_EN
  ,
  input  logic                     b_we,
  input  logic [OUT_W-1:0]         b_data
`endif
);

  localparam int PW = DATA_W + W_W;
  localparam int SW = PW + 1;
  localparam int NP = N_ELEM / 2;

  logic                     v0_q, v1_q, v2_q, v3_q;
  logic                     en0, en1, en2, en3;
  logic [N_ELEM*DATA_W-1:0] d0_q;
  logic [N_ELEM-1:0][PW-1:0] p1_q, p1_d;
  logic [NP-1:0][SW-1:0]    p2_q, p2_d;
  logic [OUT_W-1:0]         s3_q, s3_d;
  logic [N_ELEM-1:0][W_W-1:0] w_q;
  logic [15:0]              cnt_q;
`ifdef CONV_BIAS_EN
  logic [OUT_W-1:0]         bias_q;
`endif

  // Stage enables: a stage moves when it is empty or its successor moves,
  // so bubbles collapse even while the output is stalled.
  always_comb begin
    en3 = !v3_q || out_ready;
    en2 = !v2_q || en3;
    en1 = !v1_q || en2;
    en0 = !v0_q || en1;
  end

  // Datapath: products, pairwise sums and final reduction.
  always_comb begin
    p1_d = '0;
    p2_d = '0;
    s3_d = '0;
    for (int k = 0; k < N_ELEM; k++) begin
      p1_d[k] = PW'(d0_q[k*DATA_W +: DATA_W]) * PW'(w_q[k]);
    end
    for (int i = 0; i < NP; i++) begin
      p2_d[i] = SW'(p1_q[2*i]) + SW'(p1_q[2*i+1]);
    end
    for (int i = 0; i < NP; i++) begin
      s3_d = s3_d + OUT_W'(p2_q[i]);
    end
`ifdef CONV_BIAS_EN
    s3_d = s3_d + bias_q;
`endif
  end

  // Pipeline valid bits and data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      d0_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      s3_q <= '0;
    end else begin
      if (en0) begin
        v0_q <= in_valid;
        d0_q <= in_data;
      end
      if (en1) begin
        v1_q <= v0_q;
        p1_q <= p1_d;
      end
      if (en2) begin
        v2_q <= v1_q;
        p2_q <= p2_d;
      end
      if (en3) begin
        v3_q <= v2_q;
        s3_q <= s3_d;
      end
    end
  end

  // Weight file: writable only when nothing is in flight or arriving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q <= '0;
    end else if (w_we && w_ready) begin
      w_q[w_addr] <= w_data;
    end
  end

`ifdef CONV_BIAS_EN
  // Bias register shares the weight write window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_q <= '0;
    end else if (b_we && w_ready) begin
      bias_q <= b_data;
    end
  end
`endif

  // Delivered-result counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (v3_q && out_ready) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign in_ready  = en0;
  assign busy      = v0_q | v1_q | v2_q | v3_q;
  assign w_ready   = !busy && !in_valid;
  assign out_valid = v3_q;
  assign out_data  = v3_q ? s3_q : '0;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_conv_dot_pipe.sv
// Directed testbench for conv_dot_pipe at default parameters.
// Define CONV_BIAS_EN to also exercise the bias path.
module tb_conv_dot_pipe;

  localparam int N  = 32;
  localparam int DW = 4;
  localparam int OW = 13;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N*DW-1:0] in_data;
  logic          w_we;
  logic [4:0]    w_addr;
  logic [3:0]    w_data;
  logic          w_ready;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          busy;
  logic [15:0]   beat_cnt;
`ifdef CONV_BIAS_EN
  logic          b_we;
  logic [OW-1:0] b_data;
`endif

  int n_cmp;
  int n_fail;

  conv_dot_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .beat_cnt(beat_cnt)
`ifdef CONV_BIAS_EN
    , .b_we(b_we), .b_data(b_data)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Even elements take value a, odd elements take value b.
  function automatic logic [N*DW-1:0] mk_beat(input int a, input int b);
    logic [N*DW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++)
      r[k*DW +: DW] = (k % 2 == 1) ? DW'(b) : DW'(a);
    return r;
  endfunction

  // Write weight k = (k odd) ? wo : we_v. Caller sits at posedge+1, pipe idle.
  task automatic load_weights(input int we_v, input int wo);
    for (int k = 0; k < N; k++) begin
      w_we = 1'b1;
      w_addr = 5'(k);
      w_data = (k % 2 == 1) ? 4'(wo) : 4'(we_v);
      @(posedge clk); #1;
    end
    w_we = 1'b0;
  endtask

  // Send one beat into an idle pipe and return result and latency (-1 on timeout).
  task automatic run_beat(input logic [N*DW-1:0] d, output logic [OW-1:0] res, output int lat);
    in_data = d;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    res = '0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (out_valid) begin
        res = out_data;
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    w_we = 1'b0;
    w_addr = '0;
    w_data = '0;
    out_ready = 1'b1;
`ifdef CONV_BIAS_EN
    b_we = 1'b0;
    b_data = '0;
`endif
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== 13'd0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    n_cmp++; if (beat_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_beat_cnt got %0d want 0", beat_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %0b want 1", in_ready); end
    n_cmp++; if (w_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_w_ready got %0b want 1", w_ready); end
    in_valid = 1'b1;
    #1;
    n_cmp++; if (w_ready !== 1'b0) begin n_fail++; $display("FAIL w_ready_in_valid got %0b want 0", w_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_single;
    logic [OW-1:0] res;
    int lat;
    load_weights(1, 1);
    run_beat(mk_beat(15, 15), res, lat);
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL single_latency got %0d want 4", lat); end
    n_cmp++; if (res !== 13'd480) begin n_fail++; $display("FAIL single_data got %0d want 480", res); end
    n_cmp++; if (beat_cnt !== 16'd1) begin n_fail++; $display("FAIL single_beat_cnt got %0d want 1", beat_cnt); end
    n_cmp++; if (out_data !== 13'd0) begin n_fail++; $display("FAIL idle_out_data got %0d want 0", out_data); end
  endtask

  task automatic test_max;
    logic [OW-1:0] res;
    int lat;
    load_weights(15, 15);
    run_beat(mk_beat(15, 15), res, lat);
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL max_latency got %0d want 4", lat); end
    n_cmp++; if (res !== 13'd7200) begin n_fail++; $display("FAIL max_data got %0d want 7200", res); end
    n_cmp++; if (beat_cnt !== 16'd2) begin n_fail++; $display("FAIL max_beat_cnt got %0d want 2", beat_cnt); end
  endtask

  // Weights alternate 1 (even) / 2 (odd); beat i: a=i, b=15-i -> 480-16*i.
  task automatic test_back_to_back;
    int got, first, last;
    int exp_v;
    logic [15:0] cnt0;
    load_weights(1, 2);
    cnt0 = beat_cnt;
    out_ready = 1'b1;
    got = 0;
    first = -1;
    last = -1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          in_data = mk_beat(i, 15 - i);
          in_valid = 1'b1;
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && got < 10; c++) begin
          @(negedge clk);
          if (out_valid) begin
            exp_v = 480 - 16 * got;
            n_cmp++;
            if (out_data !== 13'(exp_v)) begin
              n_fail++;
              $display("FAIL b2b_data[%0d] got %0d want %0d", got, out_data, exp_v);
            end
            if (first < 0) first = c;
            last = c;
            got++;
          end
        end
      end
    join
    n_cmp++; if (got !== 10) begin n_fail++; $display("FAIL b2b_count got %0d want 10", got); end
    n_cmp++; if (last - first !== 9) begin n_fail++; $display("FAIL b2b_span got %0d want 9", last - first); end
    @(posedge clk); #1;
    n_cmp++; if (beat_cnt !== cnt0 + 16'd10) begin n_fail++; $display("FAIL b2b_beat_cnt got %0d want %0d", beat_cnt, cnt0 + 16'd10); end
  endtask

  // Beat i: a=15-i, b=i -> 240+16*i with the alternating 1/2 weights.
  task automatic test_stall;
    int idx, got, held;
    int exp_v;
    logic acc;
    logic [15:0] cnt0;
    cnt0 = beat_cnt;
    out_ready = 1'b0;
    idx = 0;
    got = 0;
    held = 0;
    in_data = mk_beat(15, 0);
    in_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        exp_v = 240 + 16 * got;
        n_cmp++;
        if (out_data !== 13'(exp_v)) begin
          n_fail++;
          $display("FAIL stall_data[%0d] got %0d want %0d", got, out_data, exp_v);
        end
        got++;
      end
      if (!out_ready && idx >= 4) begin
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 13'd240) begin
          n_fail++;
          $display("FAIL stall_hold got rdy=%0b v=%0b d=%0d want rdy=0 v=1 d=240",
                   in_ready, out_valid, out_data);
        end
        held++;
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 6) in_data = mk_beat(15 - idx, idx);
        else in_valid = 1'b0;
      end
      if (held == 5) out_ready = 1'b1;
      if (got == 6 && idx == 6) break;
    end
    n_cmp++; if (held !== 5) begin n_fail++; $display("FAIL stall_held got %0d want 5", held); end
    n_cmp++; if (got !== 6) begin n_fail++; $display("FAIL stall_count got %0d want 6", got); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_dup got out_valid=%0b want 0", out_valid); end
    end
    n_cmp++; if (beat_cnt !== cnt0 + 16'd6) begin n_fail++; $display("FAIL stall_beat_cnt got %0d want %0d", beat_cnt, cnt0 + 16'd6); end
  endtask

  task automatic test_weight_lock;
    logic [OW-1:0] res;
    int lat;
    int seen;
    out_ready = 1'b1;
    in_data = mk_beat(1, 1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w_we = 1'b1;
    w_addr = 5'd0;
    w_data = 4'd7;
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lock_busy got %0b want 1", busy); end
    n_cmp++; if (w_ready !== 1'b0) begin n_fail++; $display("FAIL lock_w_ready got %0b want 0", w_ready); end
    @(posedge clk); #1;
    w_we = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        seen = 1;
        n_cmp++; if (out_data !== 13'd48) begin n_fail++; $display("FAIL lock_inflight got %0d want 48", out_data); end
        break;
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 1) begin n_fail++; $display("FAIL lock_timeout got %0d want 1", seen); end
    for (int c = 0; c < 10 && busy; c++) begin
      @(posedge clk); #1;
    end
    run_beat(mk_beat(0, 0) | {{(N*DW-DW){1'b0}}, 4'd1}, res, lat);
    n_cmp++; if (res !== 13'd1) begin n_fail++; $display("FAIL lock_dropped got %0d want 1", res); end
    w_we = 1'b1;
    w_addr = 5'd0;
    w_data = 4'd7;
    #1;
    n_cmp++; if (w_ready !== 1'b1) begin n_fail++; $display("FAIL idle_w_ready got %0b want 1", w_ready); end
    @(posedge clk); #1;
    w_we = 1'b0;
    run_beat(mk_beat(0, 0) | {{(N*DW-DW){1'b0}}, 4'd1}, res, lat);
    n_cmp++; if (res !== 13'd7) begin n_fail++; $display("FAIL lock_updated got %0d want 7", res); end
  endtask

  task automatic test_reset_mid;
    logic [OW-1:0] res;
    int lat;
    int stale;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = mk_beat(3, 3);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got %0b want 1", busy); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %0b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 13'd0) begin n_fail++; $display("FAIL mid_out got v=%0b d=%0d want v=0 d=0", out_valid, out_data); end
    n_cmp++; if (beat_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_beat_cnt got %0d want 0", beat_cnt); end
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    n_cmp++; if (stale !== 0) begin n_fail++; $display("FAIL mid_stale got %0d want 0", stale); end
    run_beat(mk_beat(15, 15), res, lat);
    n_cmp++; if (lat !== 4 || res !== 13'd0) begin n_fail++; $display("FAIL weights_cleared got lat=%0d d=%0d want lat=4 d=0", lat, res); end
  endtask

`ifdef CONV_BIAS_EN
  task automatic test_bias;
    logic [OW-1:0] res;
    int lat;
    load_weights(1, 1);
    b_we = 1'b1;
    b_data = 13'd5;
    @(posedge clk); #1;
    b_we = 1'b0;
    run_beat(mk_beat(1, 1), res, lat);
    n_cmp++; if (res !== 13'd37) begin n_fail++; $display("FAIL bias_data got %0d want 37", res); end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_max();
    test_back_to_back();
    test_stall();
    test_weight_lock();
    test_reset_mid();
`ifdef CONV_BIAS_EN
    test_bias();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
